// File: rtl/masked_and_chain_pipe.sv
// Pipelined two-share masked AND of N_OPS operands, one registered masked gate per stage.
// Define MASKED_AND_GLITCH_REG_EN to split every gate into two register stages.
module masked_and_chain_pipe #(
  parameter int WIDTH = 4,
  parameter int N_OPS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_OPS*WIDTH-1:0]   in_s0,
  input  logic [N_OPS*WIDTH-1:0]   in_s1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_s0,
  output logic [WIDTH-1:0]         out_s1,
  output logic                     busy
);

  localparam int NG = N_OPS - 1;
`ifdef MASKED_AND_GLITCH_REG_EN
  localparam int SPG = 2;
`else
  localparam int SPG = 1;
`endif
  localparam int NSTG = NG * SPG;

  function automatic logic [WIDTH-1:0] gate_t3(input logic [WIDTH-1:0] a0, b0, b1);
    return (a0 & b0) ^ (a0 & b1) ^ b1;
  endfunction

  function automatic logic [WIDTH-1:0] gate_t5(input logic [WIDTH-1:0] a1, b0, b1);
    return (a1 & b0) ^ (a1 | b1);
  endfunction

  logic                           adv;
  logic [NSTG-1:0]                vld_q;
  logic [N_OPS-1:0][WIDTH-1:0]    opd0, opd1;
  logic [NG-1:0][WIDTH-1:0]       ga0, ga1;
  logic [NG-1:0][WIDTH-1:0]       acc0_q, acc1_q, acc0_d, acc1_d;

  assign adv       = ~vld_q[NSTG-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NSTG-1];
  assign out_s0    = acc0_q[NG-1];
  assign out_s1    = acc1_q[NG-1];
  assign busy      = |vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < NSTG; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Operand j rides a delay line until the stage holding gate j samples it.
  for (genvar j = 0; j < N_OPS; j++) begin : g_op
    if (j < 2) begin : g_direct
      assign opd0[j] = in_s0[j*WIDTH +: WIDTH];
      assign opd1[j] = in_s1[j*WIDTH +: WIDTH];
    end else begin : g_delay
      localparam int D = SPG * (j - 1);
      logic [D-1:0][WIDTH-1:0] dl0_q, dl1_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          dl0_q <= '0;
          dl1_q <= '0;
        end else if (adv) begin
          dl0_q[0] <= in_s0[j*WIDTH +: WIDTH];
          dl1_q[0] <= in_s1[j*WIDTH +: WIDTH];
          for (int i = 1; i < D; i++) begin
            dl0_q[i] <= dl0_q[i-1];
            dl1_q[i] <= dl1_q[i-1];
          end
        end
      end
      assign opd0[j] = dl0_q[D-1];
      assign opd1[j] = dl1_q[D-1];
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_gate
    if (gi == 0) begin : g_head
      assign ga0[gi] = opd0[0];
      assign ga1[gi] = opd1[0];
    end else begin : g_link
      assign ga0[gi] = acc0_q[gi-1];
      assign ga1[gi] = acc1_q[gi-1];
    end
  end

`ifdef MASKED_AND_GLITCH_REG_EN
  logic [NG-1:0][WIDTH-1:0] t3_q, t5_q, h1_q, t3_d, t5_d, h1_d;

  // First half of each gate: partial terms registered before they are combined.
  always_comb begin
    for (int gi = 0; gi < NG; gi++) begin
      t3_d[gi]   = gate_t3(ga0[gi], opd0[gi+1], opd1[gi+1]);
      t5_d[gi]   = gate_t5(ga1[gi], opd0[gi+1], opd1[gi+1]);
      h1_d[gi]   = ga1[gi];
      acc0_d[gi] = t3_q[gi] ^ t5_q[gi];
      acc1_d[gi] = h1_q[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t3_q <= '0;
      t5_q <= '0;
      h1_q <= '0;
    end else if (adv) begin
      t3_q <= t3_d;
      t5_q <= t5_d;
      h1_q <= h1_d;
    end
  end
`else
  always_comb begin
    for (int gi = 0; gi < NG; gi++) begin
      acc0_d[gi] = gate_t3(ga0[gi], opd0[gi+1], opd1[gi+1])
                 ^ gate_t5(ga1[gi], opd0[gi+1], opd1[gi+1]);
      acc1_d[gi] = ga1[gi];
    end
  end
`endif

  // Gate output stage: result mask always equals operand 0's share 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc0_q <= '0;
      acc1_q <= '0;
    end else if (adv) begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
    end
  end

endmodule

// File: tb/tb_masked_and_chain_pipe.sv
// Bench for masked_and_chain_pipe: three instances (4x3 default, 1x2 exhaustive, 8x8 random)
// checked against an unmasked AND reference model through per-instance scoreboards.
module tb_masked_and_chain_pipe;
`ifdef MASKED_AND_GLITCH_REG_EN
  localparam int SPG = 2;
`else
  localparam int SPG = 1;
`endif
  localparam int LAT_A = SPG * 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        a_iv, a_ir, a_ov, a_or, a_busy;
  logic [11:0] a_s0, a_s1;
  logic [3:0]  a_o0, a_o1;
  logic        b_iv, b_ir, b_ov, b_or, b_busy;
  logic [1:0]  b_s0, b_s1;
  logic [0:0]  b_o0, b_o1;
  logic        c_iv, c_ir, c_ov, c_or, c_busy;
  logic [63:0] c_s0, c_s1;
  logic [7:0]  c_o0, c_o1;

  masked_and_chain_pipe #(.WIDTH(4), .N_OPS(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_s0(a_s0), .in_s1(a_s1),
    .out_valid(a_ov), .out_ready(a_or), .out_s0(a_o0), .out_s1(a_o1), .busy(a_busy));
  masked_and_chain_pipe #(.WIDTH(1), .N_OPS(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_s0(b_s0), .in_s1(b_s1),
    .out_valid(b_ov), .out_ready(b_or), .out_s0(b_o0), .out_s1(b_o1), .busy(b_busy));
  masked_and_chain_pipe #(.WIDTH(8), .N_OPS(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_s0(c_s0), .in_s1(c_s1),
    .out_valid(c_ov), .out_ready(c_or), .out_s0(c_o0), .out_s1(c_o1), .busy(c_busy));

  logic [63:0] qa0[$], qa1[$], qb0[$], qb1[$], qc0[$], qc1[$];
  int na = 0, nb = 0, nc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: result is the plain AND of every operand's unmasked value; mask is operand 0's s1.
  function automatic void model(input logic [63:0] s0, input logic [63:0] s1, input int n,
                                input int w, output logic [63:0] e0, output logic [63:0] e1);
    logic [63:0] m, acc;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    acc = m;
    for (int k = 0; k < n; k++) acc = acc & ((s0 ^ s1) >> (k * w));
    e1 = s1 & m;
    e0 = (acc & m) ^ e1;
  endfunction

  task automatic step_a(input logic iv, input logic [63:0] s0, input logic [63:0] s1,
                        input logic ordy, output logic acc);
    logic [63:0] e0, e1;
    @(negedge clk);
    a_iv = iv; a_s0 = s0[11:0]; a_s1 = s1[11:0]; a_or = ordy;
    #1;
    acc = a_iv & a_ir;
    if (a_ov && a_or) begin
      na++;
      if (qa0.size() == 0) check("a_extra_out", 64'(a_ov), 64'd0);
      else begin
        check("a_out_s0", 64'(a_o0), qa0.pop_front());
        check("a_out_s1", 64'(a_o1), qa1.pop_front());
      end
    end
    if (acc) begin
      model(64'(a_s0), 64'(a_s1), 3, 4, e0, e1);
      qa0.push_back(e0); qa1.push_back(e1);
    end
  endtask

  task automatic step_b(input logic iv, input logic [63:0] s0, input logic [63:0] s1,
                        input logic ordy, output logic acc);
    logic [63:0] e0, e1;
    @(negedge clk);
    b_iv = iv; b_s0 = s0[1:0]; b_s1 = s1[1:0]; b_or = ordy;
    #1;
    acc = b_iv & b_ir;
    if (b_ov && b_or) begin
      nb++;
      if (qb0.size() == 0) check("b_extra_out", 64'(b_ov), 64'd0);
      else begin
        check("b_out_s0", 64'(b_o0), qb0.pop_front());
        check("b_out_s1", 64'(b_o1), qb1.pop_front());
      end
    end
    if (acc) begin
      model(64'(b_s0), 64'(b_s1), 2, 1, e0, e1);
      qb0.push_back(e0); qb1.push_back(e1);
    end
  endtask

  task automatic step_c(input logic iv, input logic [63:0] s0, input logic [63:0] s1,
                        input logic ordy, output logic acc);
    logic [63:0] e0, e1;
    @(negedge clk);
    c_iv = iv; c_s0 = s0; c_s1 = s1; c_or = ordy;
    #1;
    acc = c_iv & c_ir;
    if (c_ov && c_or) begin
      nc++;
      if (qc0.size() == 0) check("c_extra_out", 64'(c_ov), 64'd0);
      else begin
        check("c_out_s0", 64'(c_o0), qc0.pop_front());
        check("c_out_s1", 64'(c_o1), qc1.pop_front());
      end
    end
    if (acc) begin
      model(c_s0, c_s1, 8, 8, e0, e1);
      qc0.push_back(e0); qc1.push_back(e1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_iv = 1'b0; a_or = 1'b0; b_iv = 1'b0; b_or = 1'b0; c_iv = 1'b0; c_or = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete(); qc0.delete(); qc1.delete();
    #1;
  endtask

  task automatic drain_a();
    logic acc;
    for (int i = 0; i < 40 && qa0.size() > 0; i++) step_a(1'b0, 64'd0, 64'd0, 1'b1, acc);
    check("a_drained", 64'(qa0.size()), 64'd0);
  endtask

  initial begin
    logic        acc;
    logic [63:0] ds0, ds1;
    int          na0, nca, cyc;

    a_iv = 0; a_or = 0; a_s0 = '0; a_s1 = '0;
    b_iv = 0; b_or = 0; b_s0 = '0; b_s1 = '0;
    c_iv = 0; c_or = 0; c_s0 = '0; c_s1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(a_ov), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_out_s0", 64'(a_o0), 64'd0);
    check("rst_out_s1", 64'(a_o1), 64'd0);
    check("rst_in_ready", 64'(a_ir), 64'd1);
    check("rst_c_out_valid", 64'(c_ov), 64'd0);

    // Directed beat: x = 0xF & 0xA & 0x6 = 0x2, masked by operand 0's s1 = 0x5.
    step_a(1'b1, 64'h13A, 64'h795, 1'b1, acc);
    check("dir_accept", 64'(acc), 64'd1);
    for (int k = 1; k <= LAT_A; k++) begin
      step_a(1'b0, 64'd0, 64'd0, 1'b1, acc);
      if (k < LAT_A) check("dir_early_valid", 64'(a_ov), 64'd0);
      else begin
        check("dir_valid", 64'(a_ov), 64'd1);
        check("dir_s0", 64'(a_o0), 64'h7);
        check("dir_s1", 64'(a_o1), 64'h5);
        check("dir_xor", 64'(a_o0 ^ a_o1), 64'h2);
      end
    end
    drain_a();

    // Back-pressure: offer beats with the consumer stalled, then release.
    ds0 = 64'($urandom); ds1 = 64'($urandom);
    for (int c = 0; c < 8; c++) begin
      step_a(1'b1, ds0, ds1, 1'b0, acc);
      if (acc) begin ds0 = 64'($urandom); ds1 = 64'($urandom); end
      if (a_ov) begin
        check("bp_in_ready", 64'(a_ir), 64'd0);
        if (qa0.size() > 0) begin
          check("bp_hold_s0", 64'(a_o0), qa0[0]);
          check("bp_hold_s1", 64'(a_o1), qa1[0]);
        end
      end
    end
    check("bp_filled", 64'(a_ov), 64'd1);
    check("bp_depth", 64'(qa0.size()), 64'(LAT_A));
    for (int i = 0; i < 20 && qa0.size() > 0; i++) begin
      step_a(1'b0, 64'd0, 64'd0, 1'b1, acc);
      check("bp_release_valid", 64'(a_ov), 64'd1);
    end
    drain_a();

    // Continuous streaming: 20 beats with no gaps once the pipe has filled.
    na0 = na;
    for (int i = 0; i < 20 + LAT_A; i++) begin
      step_a(i < 20, 64'($urandom), 64'($urandom), 1'b1, acc);
      if (i < 20) check("stream_accept", 64'(acc), 64'd1);
      if (i >= 1) check("stream_busy", 64'(a_busy), 64'd1);
      if (i >= LAT_A) check("stream_valid", 64'(a_ov), 64'd1);
    end
    check("stream_count", 64'(na - na0), 64'd20);
    drain_a();

    // Reset with two beats in flight drops them; a fresh beat then completes.
    step_a(1'b1, 64'($urandom), 64'($urandom), 1'b0, acc);
    step_a(1'b1, 64'($urandom), 64'($urandom), 1'b0, acc);
    check("pre_rst_busy", 64'(a_busy), 64'd1);
    do_reset();
    check("mid_rst_out_valid", 64'(a_ov), 64'd0);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    check("mid_rst_out_s0", 64'(a_o0), 64'd0);
    check("mid_rst_out_s1", 64'(a_o1), 64'd0);
    check("mid_rst_in_ready", 64'(a_ir), 64'd1);
    na0 = na;
    step_a(1'b1, 64'h13A, 64'h795, 1'b1, acc);
    for (int i = 0; i < 10 && na == na0; i++) step_a(1'b0, 64'd0, 64'd0, 1'b1, acc);
    check("post_rst_count", 64'(na - na0), 64'd1);

    // Random gaps on the default instance.
    for (int i = 0; i < 300; i++)
      step_a($urandom_range(0, 2) != 0, 64'($urandom), 64'($urandom),
             $urandom_range(0, 2) != 0, acc);
    drain_a();

    // Exhaustive 1-bit, 2-operand share combinations streamed back-to-back.
    for (int i = 0; i < 16; i++) begin
      step_b(1'b1, 64'(i & 3), 64'((i >> 2) & 3), 1'b1, acc);
      check("b_accept", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 20 && qb0.size() > 0; i++) step_b(1'b0, 64'd0, 64'd0, 1'b1, acc);
    check("b_count", 64'(nb), 64'd16);
    check("b_drained", 64'(qb0.size()), 64'd0);

    // Random 8-operand, 8-bit traffic with valid and ready gaps.
    nca = 0; cyc = 0;
    while (nca < 1000 && cyc < 6000) begin
      step_c($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3) != 0, acc);
      if (acc) nca++;
      cyc++;
    end
    check("c_accepted", 64'(nca), 64'd1000);
    for (int i = 0; i < 40 && qc0.size() > 0; i++) step_c(1'b0, 64'd0, 64'd0, 1'b1, acc);
    check("c_count", 64'(nc), 64'd1000);
    check("c_drained", 64'(qc0.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
